mem_cmd_burst_splitter: RTL and testbench
=========================================

Name: mem_cmd_burst_splitter

Overview:
Parametrised successor to the single-beat memory command path. It accepts one memory command (address, byte length, tag) and splits it into sub-commands that never cross a MAX_BURST_BYTES address boundary. An outstanding-credit counter throttles issue, and the counter is returned through the memory status stream. The block sits between an engine's command generator and the memory controller's command and status ports.

Parameters:
ADDR_WIDTH, 64, address width in bits
LEN_WIDTH, 32, byte-length width in bits
TAG_WIDTH, 8, tag width in bits (engine tags such as 8'h0a / 8'h0b)
MAX_BURST_BYTES, 4096, power of two; no sub-command crosses a multiple of it
MAX_OUTSTANDING, 16, maximum issued sub-commands without a status response
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_cmd_valid  in  1  input command valid
s_cmd_ready  out  1  input command ready
s_cmd_address  in  ADDR_WIDTH  start byte address
s_cmd_length  in  LEN_WIDTH  byte length
s_cmd_tag  in  TAG_WIDTH  command tag
m_cmd_valid  out  1  sub-command valid
m_cmd_ready  in  1  sub-command ready
m_cmd_address  out  ADDR_WIDTH  sub-command address
m_cmd_length  out  LEN_WIDTH  sub-command length
m_cmd_tag  out  TAG_WIDTH  copy of s_cmd_tag
m_cmd_last  out  1  final sub-command of the parent command
s_sts_valid  in  1  completion status valid
s_sts_ready  out  1  completion status ready
s_sts_data  in  8  status code; 0 = OK
outstanding  out  CNT_W  current outstanding count
busy  out  1  state != IDLE or outstanding != 0
err_status  out  1  sticky: a status with nonzero data was received
err_status_code  out  8  first nonzero status code received
err_underflow  out  1  sticky: a status arrived with outstanding == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; all registers and outputs are 0, except s_cmd_ready = 1 and s_sts_ready = 1.
- Two-state FSM, IDLE and ISSUE.
- IDLE:
  - s_cmd_ready = 1.
  - On handshake with length > 0: latch cur_addr = address, remaining = length, tag; go to ISSUE.
  - On handshake with length == 0: consume the command, emit nothing, stay in IDLE.
- ISSUE:
  - s_cmd_ready = 0.
  - piece = min(remaining, MAX_BURST_BYTES - (cur_addr mod MAX_BURST_BYTES)).
  - piece is registered, so m_cmd_* come from registers with no combinational path from s_cmd_*.
  - m_cmd_valid = (outstanding < MAX_OUTSTANDING).
  - m_cmd_last = (piece == remaining).
- On m_cmd handshake:
  - cur_addr += piece; remaining -= piece.
  - The next piece is valid the following cycle, giving back-to-back throughput of 1 per cycle.
  - If last, go to IDLE.
- Latency:
  - First m_cmd_valid is 1 cycle after the s_cmd handshake.
  - One bubble cycle (IDLE) separates consecutive parent commands.
- Valid stability: once asserted, m_cmd_valid and all m_cmd fields hold until handshake. This holds because outstanding cannot increase without a handshake.
- Outstanding counter:
  - +1 on m_cmd handshake; -1 on s_sts handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never wraps.
- s_sts_ready is always 1.
- Status with outstanding == 0 and no simultaneous issue: counter unchanged, err_underflow set.
- Status with data != 0:
  - err_status set.
  - err_status_code captured only when err_status was 0; it holds the first error.
  - The counter is still decremented.
- Sticky error flags clear only on reset.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top of the address space is not flagged.
- Reset mid-operation: the command in flight and the outstanding count are discarded; the block returns to IDLE in the same cycle as rst_n assertion.

Test Plan:
- Boundary split: cmd addr 0x0F80, len 0x2100, tag 0x0a, m_cmd_ready = 1 → exactly four sub-commands, all tag 0x0a, on consecutive cycles starting 1 cycle after accept:
  - 0x0F80 / 0x80
  - 0x1000 / 0x1000
  - 0x2000 / 0x1000
  - 0x3000 / 0x80, last = 1
- Aligned single: addr 0x4000, len 0x40 → one sub-command 0x4000 / 0x40 with last = 1; s_cmd_ready returns to 1 one cycle later.
- Credit throttle, MAX_OUTSTANDING = 2: cmd addr 0, len 0x4000, no status → two sub-commands issued, then m_cmd_valid = 0 and outstanding = 2. One OK status → third sub-command valid the next cycle.
- Simultaneous events: m_cmd handshake and s_sts handshake in the same cycle with outstanding = 1 → outstanding stays 1.
- Errors:
  - Status 0x03 then status 0x05 → err_status = 1, err_status_code = 0x03.
  - Status with outstanding = 0 → err_underflow = 1, outstanding = 0.
  - Zero-length cmd → accepted, no m_cmd_valid.
- Async reset: assert rst_n = 0 mid-split after sub-command 2 → m_cmd_valid, outstanding and busy are 0 immediately. A new command after release splits from its own address.

Source files
------------

// File: rtl/mem_cmd_burst_splitter.sv
// rtl/mem_cmd_burst_splitter.sv - splits memory commands at burst boundaries under an outstanding-credit limit
module mem_cmd_burst_splitter #(
   parameter int ADDR_WIDTH      = 64,
   parameter int LEN_WIDTH       = 32,
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_BURST_BYTES = 4096,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] s_cmd_address,
   input  logic [LEN_WIDTH-1:0]  s_cmd_length,
   input  logic [TAG_WIDTH-1:0]  s_cmd_tag,
   output logic                  m_cmd_valid,
   input  logic                  m_cmd_ready,
   output logic [ADDR_WIDTH-1:0] m_cmd_address,
   output logic [LEN_WIDTH-1:0]  m_cmd_length,
   output logic [TAG_WIDTH-1:0]  m_cmd_tag,
   output logic                  m_cmd_last,
   input  logic                  s_sts_valid,
   output logic                  s_sts_ready,
   input  logic [7:0]            s_sts_data,
   output logic [CNT_W-1:0]      outstanding,
   output logic                  busy,
   output logic                  err_status,
   output logic [7:0]            err_status_code,
   output logic                  err_underflow
);

   localparam int                   OFF_W     = $clog2(MAX_BURST_BYTES);
   localparam logic [LEN_WIDTH-1:0] BURST_LEN = LEN_WIDTH'(MAX_BURST_BYTES);
   localparam logic [CNT_W-1:0]     MAX_OUT   = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic [LEN_WIDTH-1:0]  piece_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [CNT_W-1:0]      out_q, out_d;
   logic                  err_status_q;
   logic [7:0]            err_code_q;
   logic                  err_underflow_q;

   logic                  m_hs;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [LEN_WIDTH-1:0]  next_rem;

   // Bytes that fit before the next burst boundary, clipped to what is left.
   function automatic logic [LEN_WIDTH-1:0] piece_of(input logic [OFF_W-1:0]     off,
                                                     input logic [LEN_WIDTH-1:0] len);
      logic [LEN_WIDTH-1:0] room;
      room = BURST_LEN - LEN_WIDTH'(off);
      return (len < room) ? len : room;
   endfunction

   assign s_cmd_ready     = (state_q == IDLE);
   assign s_sts_ready     = 1'b1;
   assign m_cmd_valid     = (state_q == ISSUE) && (out_q < MAX_OUT);
   assign m_cmd_address   = addr_q;
   assign m_cmd_length    = piece_q;
   assign m_cmd_tag       = tag_q;
   assign m_cmd_last      = (piece_q == rem_q);
   assign outstanding     = out_q;
   assign busy            = (state_q != IDLE) || (out_q != '0);
   assign err_status      = err_status_q;
   assign err_status_code = err_code_q;
   assign err_underflow   = err_underflow_q;

   assign m_hs      = m_cmd_valid && m_cmd_ready;
   assign next_addr = addr_q + ADDR_WIDTH'(piece_q);
   assign next_rem  = rem_q - piece_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         piece_q <= '0;
         tag_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Zero-length commands are consumed here without producing output.
               if (s_cmd_valid && (s_cmd_length != '0)) begin
                  addr_q  <= s_cmd_address;
                  rem_q   <= s_cmd_length;
                  tag_q   <= s_cmd_tag;
                  piece_q <= piece_of(s_cmd_address[OFF_W-1:0], s_cmd_length);
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_hs) begin
                  addr_q  <= next_addr;
                  rem_q   <= next_rem;
                  piece_q <= piece_of(next_addr[OFF_W-1:0], next_rem);
                  if (m_cmd_last) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A status with nothing outstanding leaves the count alone unless an issue cancels it out.
   always_comb begin
      out_d = out_q;
      if (m_hs && !s_sts_valid) begin
         out_d = out_q + CNT_W'(1);
      end else if (!m_hs && s_sts_valid && (out_q != '0)) begin
         out_d = out_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q           <= '0;
         err_status_q    <= 1'b0;
         err_code_q      <= '0;
         err_underflow_q <= 1'b0;
      end else begin
         out_q <= out_d;
         if (s_sts_valid && (s_sts_data != 8'h00)) begin
            err_status_q <= 1'b1;
            if (!err_status_q) begin
               err_code_q <= s_sts_data;
            end
         end
         if (s_sts_valid && !m_hs && (out_q == '0)) begin
            err_underflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_cmd_burst_splitter.sv
// tb/tb_mem_cmd_burst_splitter.sv - self-checking bench for mem_cmd_burst_splitter
module tb_mem_cmd_burst_splitter;

   logic        clk;
   logic        rst_n;

   logic        s_cmd_valid, s_cmd_ready;
   logic [63:0] s_cmd_address;
   logic [31:0] s_cmd_length;
   logic [7:0]  s_cmd_tag;
   logic        m_cmd_valid, m_cmd_ready, m_cmd_last;
   logic [63:0] m_cmd_address;
   logic [31:0] m_cmd_length;
   logic [7:0]  m_cmd_tag;
   logic        s_sts_valid, s_sts_ready;
   logic [7:0]  s_sts_data;
   logic [4:0]  outstanding;
   logic        busy, err_status, err_underflow;
   logic [7:0]  err_status_code;

   logic        t_s_cmd_valid, t_s_cmd_ready;
   logic [63:0] t_s_cmd_address;
   logic [31:0] t_s_cmd_length;
   logic [7:0]  t_s_cmd_tag;
   logic        t_m_cmd_valid, t_m_cmd_ready, t_m_cmd_last;
   logic [63:0] t_m_cmd_address;
   logic [31:0] t_m_cmd_length;
   logic [7:0]  t_m_cmd_tag;
   logic        t_s_sts_valid, t_s_sts_ready;
   logic [7:0]  t_s_sts_data;
   logic [1:0]  t_outstanding;
   logic        t_busy, t_err_status, t_err_underflow;
   logic [7:0]  t_err_status_code;

   mem_cmd_burst_splitter dut (
      .clk(clk), .rst_n(rst_n),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length), .s_cmd_tag(s_cmd_tag),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
      .m_cmd_tag(m_cmd_tag), .m_cmd_last(m_cmd_last),
      .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
      .outstanding(outstanding), .busy(busy),
      .err_status(err_status), .err_status_code(err_status_code), .err_underflow(err_underflow)
   );

   mem_cmd_burst_splitter #(.MAX_OUTSTANDING(2)) u_thr (
      .clk(clk), .rst_n(rst_n),
      .s_cmd_valid(t_s_cmd_valid), .s_cmd_ready(t_s_cmd_ready),
      .s_cmd_address(t_s_cmd_address), .s_cmd_length(t_s_cmd_length), .s_cmd_tag(t_s_cmd_tag),
      .m_cmd_valid(t_m_cmd_valid), .m_cmd_ready(t_m_cmd_ready),
      .m_cmd_address(t_m_cmd_address), .m_cmd_length(t_m_cmd_length),
      .m_cmd_tag(t_m_cmd_tag), .m_cmd_last(t_m_cmd_last),
      .s_sts_valid(t_s_sts_valid), .s_sts_ready(t_s_sts_ready), .s_sts_data(t_s_sts_data),
      .outstanding(t_outstanding), .busy(t_busy),
      .err_status(t_err_status), .err_status_code(t_err_status_code), .err_underflow(t_err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] len;
      logic [7:0]  tag;
      logic        last;
   } sub_t;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] len;
      logic [7:0]  tag;
      int          n;
      bit          stall;
   } vec_t;

   sub_t sb[$];
   vec_t vecs[8];
   int   total = 0;
   int   bad = 0;
   int   hs_cnt = 0;
   logic hold_v = 1'b0;
   sub_t hold_s;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent split model: walk the range, stopping at every 4 KiB boundary.
   task automatic model_push(input logic [63:0] a, input logic [31:0] r, input logic [7:0] t);
      logic [63:0] room;
      logic [31:0] p;
      while (r != 32'd0) begin
         room = 64'd4096 - {52'd0, a[11:0]};
         p    = ({32'd0, r} < room) ? r : room[31:0];
         sb.push_back('{a, p, t, (p == r)});
         a = a + {32'd0, p};
         r = r - p;
      end
   endtask

   // One clock: scoreboard the main DUT at the falling edge, return 1 time unit after the rising edge.
   task automatic cycle();
      sub_t e;
      @(negedge clk);
      if (hold_v) begin
         chk("hold_valid", m_cmd_valid, 1);
         chk("hold_addr", m_cmd_address, hold_s.addr);
         chk("hold_len", m_cmd_length, hold_s.len);
      end
      if (m_cmd_valid && m_cmd_ready) begin
         hs_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: unexpected sub-command addr 0x%0h len 0x%0h", m_cmd_address, m_cmd_length);
         end else begin
            e = sb.pop_front();
            chk("sub_addr", m_cmd_address, e.addr);
            chk("sub_len", m_cmd_length, e.len);
            chk("sub_tag", m_cmd_tag, e.tag);
            chk("sub_last", m_cmd_last, e.last);
         end
      end
      hold_v = m_cmd_valid && !m_cmd_ready;
      hold_s = '{m_cmd_address, m_cmd_length, m_cmd_tag, m_cmd_last};
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, input logic [7:0] t);
      int budget = 20;
      while (!s_cmd_ready && budget > 0) begin
         cycle();
         budget--;
      end
      if (budget == 0) chk("cmd_ready_timeout", s_cmd_ready, 1);
      s_cmd_valid   = 1'b1;
      s_cmd_address = a;
      s_cmd_length  = l;
      s_cmd_tag     = t;
      cycle();
      s_cmd_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         s_sts_valid = 1'b1;
         s_sts_data  = 8'h00;
         cycle();
      end
      s_sts_valid = 1'b0;
   endtask

   task automatic t_sts(input logic [7:0] d);
      t_s_sts_valid = 1'b1;
      t_s_sts_data  = d;
      cycle();
      t_s_sts_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{64'h4000, 32'h40, 8'h0b, 1, 1'b0};
      vecs[1] = '{64'h0FFF, 32'h2, 8'h0a, 2, 1'b0};
      vecs[2] = '{64'h1000, 32'h1000, 8'h0b, 1, 1'b0};
      vecs[3] = '{64'h1000, 32'h1001, 8'h0c, 2, 1'b0};
      vecs[4] = '{64'h0010, 32'h3000, 8'h0d, 4, 1'b1};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_F800, 32'h1000, 8'h0e, 2, 1'b0};
      vecs[6] = '{64'h0123, 32'h0, 8'h0f, 0, 1'b0};
      vecs[7] = '{64'h07F0, 32'h1820, 8'h10, 3, 1'b1};

      rst_n = 1'b0;
      s_cmd_valid = 1'b0; s_cmd_address = '0; s_cmd_length = '0; s_cmd_tag = '0;
      m_cmd_ready = 1'b1; s_sts_valid = 1'b0; s_sts_data = '0;
      t_s_cmd_valid = 1'b0; t_s_cmd_address = '0; t_s_cmd_length = '0; t_s_cmd_tag = '0;
      t_m_cmd_ready = 1'b0; t_s_sts_valid = 1'b0; t_s_sts_data = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      chk("rst_s_cmd_ready", s_cmd_ready, 1);
      chk("rst_s_sts_ready", s_sts_ready, 1);
      chk("rst_m_cmd_valid", m_cmd_valid, 0);
      chk("rst_m_cmd_addr", m_cmd_address, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", {err_status, err_underflow, err_status_code}, 0);
      chk("rst_t_s_sts_ready", t_s_sts_ready, 1);

      // Boundary split: four pieces on the four cycles right after accept.
      sb.push_back('{64'h0F80, 32'h80, 8'h0a, 1'b0});
      sb.push_back('{64'h1000, 32'h1000, 8'h0a, 1'b0});
      sb.push_back('{64'h2000, 32'h1000, 8'h0a, 1'b0});
      sb.push_back('{64'h3000, 32'h80, 8'h0a, 1'b1});
      hs_cnt = 0;
      send_cmd(64'h0F80, 32'h2100, 8'h0a);
      chk("split_first_valid", m_cmd_valid, 1);
      chk("split_cmd_ready_low", s_cmd_ready, 0);
      for (int i = 0; i < 4; i++) cycle();
      chk("split_hs_count", hs_cnt, 4);
      chk("split_back_idle", s_cmd_ready, 1);
      chk("split_valid_off", m_cmd_valid, 0);
      chk("split_outstanding", outstanding, 4);
      drain(4);
      chk("split_drained", outstanding, 0);

      // Aligned single piece: ready comes back one cycle after its handshake.
      sb.push_back('{64'h4000, 32'h40, 8'h0b, 1'b1});
      send_cmd(64'h4000, 32'h40, 8'h0b);
      chk("single_last", m_cmd_last, 1);
      cycle();
      chk("single_ready_back", s_cmd_ready, 1);
      drain(1);

      for (int v = 0; v < 8; v++) begin
         int budget;
         hs_cnt = 0;
         model_push(vecs[v].addr, vecs[v].len, vecs[v].tag);
         send_cmd(vecs[v].addr, vecs[v].len, vecs[v].tag);
         budget = 60;
         while (sb.size() != 0 && budget > 0) begin
            m_cmd_ready = vecs[v].stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            budget--;
         end
         if (budget == 0) chk("vec_timeout", sb.size(), 0);
         m_cmd_ready = 1'b1;
         cycle();
         cycle();
         chk($sformatf("vec%0d_hs_count", v), hs_cnt, vecs[v].n);
         chk($sformatf("vec%0d_outstanding", v), outstanding, vecs[v].n);
         drain(vecs[v].n);
         chk($sformatf("vec%0d_busy_clear", v), busy, 0);
         sb.delete();
      end

      // Credit throttle on the two-credit instance.
      t_m_cmd_ready   = 1'b1;
      t_s_cmd_address = 64'h0;
      t_s_cmd_length  = 32'h4000;
      t_s_cmd_tag     = 8'h0b;
      t_s_cmd_valid   = 1'b1;
      cycle();
      t_s_cmd_valid = 1'b0;
      chk("thr_p0_valid", t_m_cmd_valid, 1);
      chk("thr_p0_addr", t_m_cmd_address, 64'h0);
      chk("thr_p0_len", t_m_cmd_length, 32'h1000);
      chk("thr_p0_tag", t_m_cmd_tag, 8'h0b);
      cycle();
      chk("thr_p1_out", t_outstanding, 1);
      chk("thr_p1_addr", t_m_cmd_address, 64'h1000);
      cycle();
      chk("thr_stall_valid", t_m_cmd_valid, 0);
      chk("thr_stall_out", t_outstanding, 2);
      cycle();
      cycle();
      chk("thr_still_stalled", t_m_cmd_valid, 0);
      chk("thr_busy", t_busy, 1);
      t_sts(8'h00);
      chk("thr_resume_valid", t_m_cmd_valid, 1);
      chk("thr_resume_out", t_outstanding, 1);
      chk("thr_resume_addr", t_m_cmd_address, 64'h2000);
      t_sts(8'h00);
      chk("simul_out", t_outstanding, 1);
      chk("thr_p3_addr", t_m_cmd_address, 64'h3000);
      chk("thr_p3_last", t_m_cmd_last, 1);
      cycle();
      chk("thr_done_ready", t_s_cmd_ready, 1);
      chk("thr_done_out", t_outstanding, 2);

      // Error capture and underflow.
      t_sts(8'h03);
      chk("err_flag", t_err_status, 1);
      chk("err_code_first", t_err_status_code, 8'h03);
      t_sts(8'h05);
      chk("err_code_held", t_err_status_code, 8'h03);
      chk("err_dec_out", t_outstanding, 0);
      chk("err_no_underflow", t_err_underflow, 0);
      t_sts(8'h00);
      chk("underflow_flag", t_err_underflow, 1);
      chk("underflow_out", t_outstanding, 0);
      chk("underflow_busy", t_busy, 0);

      // Asynchronous reset in the middle of a split.
      hs_cnt = 0;
      sb.push_back('{64'h0F80, 32'h80, 8'h0a, 1'b0});
      sb.push_back('{64'h1000, 32'h1000, 8'h0a, 1'b0});
      send_cmd(64'h0F80, 32'h2100, 8'h0a);
      cycle();
      cycle();
      chk("arst_pre_hs", hs_cnt, 2);
      chk("arst_pre_valid", m_cmd_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", m_cmd_valid, 0);
      chk("arst_out", outstanding, 0);
      chk("arst_busy", busy, 0);
      chk("arst_t_err", t_err_status, 0);
      cycle();
      rst_n = 1'b1;
      cycle();
      hs_cnt = 0;
      sb.push_back('{64'h5000, 32'h1000, 8'h0b, 1'b0});
      sb.push_back('{64'h6000, 32'h800, 8'h0b, 1'b1});
      send_cmd(64'h5000, 32'h1800, 8'h0b);
      for (int i = 0; i < 3; i++) cycle();
      chk("post_rst_hs", hs_cnt, 2);
      chk("post_rst_out", outstanding, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
